// File: rtl/decode_pipe_if.sv
// Fetch->decode and decode->execute handshake bundle for decode_pipe.
interface decode_pipe_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
);
  // fetch -> decode
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  // decode -> execute
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rd;
  logic [2:0]      out_fun3;
  logic            out_load;
  logic            out_store;
  logic            out_jump;
  logic            out_branch;
  logic            out_taken;
  logic            out_wr;

  // Pipeline neighbours: fetch drives the request, execute drives out_ready.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_fun3, out_load, out_store, out_jump, out_branch,
           out_taken, out_wr
  );

  // Decode stage view.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_fun3, out_load, out_store, out_jump, out_branch,
           out_taken, out_wr
  );
endinterface

// File: rtl/decode_pipe.sv
// RV32I decode stage: regfile read with forwarding, immediate generation,
// branch resolution, load-use stall and a single ID/EX output register.
module decode_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned RAW    = $clog2(NREG),
  parameter int unsigned FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  decode_pipe_if.slave    bus,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_wr,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic            flush
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
    logic [2:0]      fun3;
    logic            load;
    logic            store;
    logic            jump;
    logic            branch;
    logic            taken;
    logic            wr;
  } out_t;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  out_t            out_q, out_d, dec;
  logic            valid_q, valid_d;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      fun3;
  logic [RAW-1:0]  rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            use_rs1, use_rs2;
  logic            ex_fwd_ok;
  logic            stall;
  logic            accept;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign fun3   = instr[14:12];
  assign rd     = RAW'(instr[11:7]);
  assign rs1    = RAW'(instr[19:15]);
  assign rs2    = RAW'(instr[24:20]);

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  assign ex_fwd_ok = (FWD_EN != 0) && ex_wr && !ex_is_load;

  // Operand select: x0, then EX forward, then WB bypass, then regfile.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (wb_en && (wb_rd == rs1)) rs1_val = wb_data;
    if (wb_en && (wb_rd == rs2)) rs2_val = wb_data;
    if (ex_fwd_ok && (ex_rd == rs1)) rs1_val = ex_data;
    if (ex_fwd_ok && (ex_rd == rs2)) rs2_val = ex_data;
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end

  // Opcode decode, immediate select and branch resolution.
  always_comb begin
    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    dec.rd       = rd;
    dec.fun3     = fun3;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.wr  = (rd != '0);
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.wr  = (rd != '0);
      end
      OPC_LOAD: begin
        use_rs1  = 1'b1;
        dec.imm  = imm_i;
        dec.load = 1'b1;
        dec.wr   = (rd != '0);
      end
      OPC_STORE: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec.imm   = imm_s;
        dec.store = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (fun3)
          3'b000:  dec.taken = (rs1_val == rs2_val);
          3'b001:  dec.taken = (rs1_val != rs2_val);
          3'b100:  dec.taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  dec.taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  dec.taken = (rs1_val <  rs2_val);
          3'b111:  dec.taken = (rs1_val >= rs2_val);
          default: dec.taken = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec.imm  = imm_j;
        dec.jump = 1'b1;
        dec.wr   = (rd != '0);
      end
      OPC_JALR: begin
        use_rs1  = 1'b1;
        dec.imm  = imm_i;
        dec.jump = 1'b1;
        dec.wr   = (rd != '0);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = imm_u;
        dec.wr  = (rd != '0);
      end
      default: ;
    endcase
  end

  // Load-use hazard: the loaded value is not available for forwarding yet.
  assign stall = bus.in_valid && ex_wr && ex_is_load && (ex_rd != '0) &&
                 ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));

  assign bus.in_ready = !rst && !flush && !stall && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register next state: flush kills, accept loads, drain clears valid.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      out_d   = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Regfile write; x0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (wb_en && (wb_rd != '0)) rf_d[wb_rd] = wb_data;
  end

  // State update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      rf_q    <= rf_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_rs1_data = out_q.rs1_data;
  assign bus.out_rs2_data = out_q.rs2_data;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_fun3     = out_q.fun3;
  assign bus.out_load     = out_q.load;
  assign bus.out_store    = out_q.store;
  assign bus.out_jump     = out_q.jump;
  assign bus.out_branch   = out_q.branch;
  assign bus.out_taken    = out_q.taken;
  assign bus.out_wr       = out_q.wr;

endmodule
